// File: rtl/l2_if_pkg.sv
// -----------------------------------------------------------------------------
// l2_if_pkg
// Command encoding and line-address width shared by the L1 data cache and the
// L2 command queue. Both sides import this package so that they agree on the
// command codes.
// -----------------------------------------------------------------------------
package l2_if_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,   // WRITE / RWIM
        CMD_RSVD  = 2'b11
    } l2_cmd_e;

    localparam int LINE_ADDR_W = 26;   // byte address bits [31:6]

    // Only READ and WRITE are ever stored; NOP and the reserved code are ignored.
    function automatic logic is_queued_cmd(input logic [1:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/l2_cmd_fifo.sv
// -----------------------------------------------------------------------------
// l2_cmd_fifo
// DEPTH x W circular buffer with read/write pointers and an occupancy count.
// The head entry is read straight from storage, so the data output never
// depends combinationally on the write data.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   push_i        write wdata_i at the tail (caller guarantees !full_o or pop_i)
//   pop_i         retire the head entry (caller guarantees !empty_o)
//   wdata_i       entry to store
//   rdata_o       head entry (undefined contents when empty_o)
//   occupancy_o   number of entries held, 0..DEPTH
//   full_o        occupancy_o == DEPTH
//   empty_o       occupancy_o == 0
// -----------------------------------------------------------------------------
module l2_cmd_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 28,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic [OCC_W-1:0] occupancy_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // NOTE: combinational next-state logic uses blocking '=' with every output
    // assigned a default first (no latches); state registers use only '<='.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        // DEPTH is a power of two, so the pointers wrap by natural overflow.
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;   // idle, or push and pop together
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only observed after
    // it has been written, and validity is carried by the occupancy count.
    // When full with push and pop together wr_ptr == rd_ptr: the popped head is
    // read before the edge and the new entry lands in the freed slot.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign occupancy_o = occ_q;
    assign full_o      = (occ_q == OCC_W'(DEPTH));
    assign empty_o     = (occ_q == '0);

endmodule

// File: rtl/l2_cmd_queue.sv
// -----------------------------------------------------------------------------
// l2_cmd_queue
// Captures per-cycle line commands from the L1 data cache (which cannot be
// stalled) and drains them in order to the L2 port over a valid/ready
// handshake. Keeps issue/drop statistics.
//
// Build option: define WRITE_MERGE_EN to fold a WRITE to the same line as the
// most recently queued WRITE into that entry instead of storing it again.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   cmd_in / add_in          cache command (00 NOP, 01 READ, 10 WRITE, 11 rsvd)
//                            and line address
//   l2_valid/l2_cmd/l2_add   head entry toward L2 (NOP / 0 when empty)
//   l2_ready                 L2 takes the head this cycle
//   full, occupancy          queue status
//   rd_issued, wr_issued     READs / WRITEs accepted by L2
//   drop_cnt                 commands lost because the queue was full
//   merge_cnt                WRITEs merged (always 0 without WRITE_MERGE_EN)
// -----------------------------------------------------------------------------
module l2_cmd_queue
    import l2_if_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int ADDR_W = LINE_ADDR_W,
    parameter  int CNT_W  = 32,
    localparam int OCC_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cmd_in,
    input  logic [ADDR_W-1:0] add_in,
    output logic              l2_valid,
    output logic [1:0]        l2_cmd,
    output logic [ADDR_W-1:0] l2_add,
    input  logic              l2_ready,
    output logic              full,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  rd_issued,
    output logic [CNT_W-1:0]  wr_issued,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  merge_cnt
);

    localparam int ENTRY_W = 2 + ADDR_W;

    logic [ENTRY_W-1:0] head_entry;
    logic               empty;
    logic               req;        // cache presented a storable command
    logic               pop;
    logic               merge;
    logic               fifo_push;
    logic               drop;

    logic [CNT_W-1:0] rd_issued_q, wr_issued_q, drop_cnt_q;

    assign req = is_queued_cmd(cmd_in);
    assign pop = l2_valid & l2_ready;

`ifdef WRITE_MERGE_EN
    // Copy of the last entry pushed. Whenever the queue is non-empty this is
    // exactly the tail entry, so no extra valid tracking is needed.
    logic [1:0]        last_cmd_q;
    logic [ADDR_W-1:0] last_add_q;
    logic [CNT_W-1:0]  merge_cnt_q;

    // A tail that is also the head being popped this cycle is leaving, so it
    // cannot absorb the write.
    assign merge = (cmd_in == CMD_WRITE) && !empty &&
                   (last_cmd_q == CMD_WRITE) && (last_add_q == add_in) &&
                   !(pop && (occupancy == OCC_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cmd_q  <= CMD_NOP;
            last_add_q  <= '0;
            merge_cnt_q <= '0;
        end else begin
            if (fifo_push) begin
                last_cmd_q <= cmd_in;
                last_add_q <= add_in;
            end
            if (merge) merge_cnt_q <= merge_cnt_q + CNT_W'(1);
        end
    end

    assign merge_cnt = merge_cnt_q;
`else
    assign merge     = 1'b0;
    assign merge_cnt = '0;
`endif

    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign fifo_push = req && !merge && (!full || pop);
    assign drop      = req && !merge && full && !pop;

    l2_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .pop_i       (pop),
        .wdata_i     ({cmd_in, add_in}),
        .rdata_o     (head_entry),
        .occupancy_o (occupancy),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Stale storage is masked so an empty queue always presents NOP / 0.
    assign l2_valid = !empty;
    assign l2_cmd   = empty ? CMD_NOP : head_entry[ENTRY_W-1 -: 2];
    assign l2_add   = empty ? '0      : head_entry[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_issued_q <= '0;
            wr_issued_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (pop && (l2_cmd == CMD_READ))  rd_issued_q <= rd_issued_q + CNT_W'(1);
            if (pop && (l2_cmd == CMD_WRITE)) wr_issued_q <= wr_issued_q + CNT_W'(1);
            if (drop)                         drop_cnt_q  <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign rd_issued = rd_issued_q;
    assign wr_issued = wr_issued_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_l2_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_l2_cmd_queue
// Directed bench for l2_cmd_queue (DEPTH=8, ADDR_W=26, CNT_W=32). Inputs are
// driven and outputs sampled 1 time unit after the rising edge. Expectations
// for the merge scenario follow WRITE_MERGE_EN.
// -----------------------------------------------------------------------------
module tb_l2_cmd_queue;
    import l2_if_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 26;
    localparam int CNT_W  = 32;
    localparam int OCC_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        cmd_in;
    logic [ADDR_W-1:0] add_in;
    logic              l2_valid;
    logic [1:0]        l2_cmd;
    logic [ADDR_W-1:0] l2_add;
    logic              l2_ready;
    logic              full;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  rd_issued, wr_issued, drop_cnt, merge_cnt;

    int checks   = 0;
    int failures = 0;

    l2_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_in    (cmd_in),
        .add_in    (add_in),
        .l2_valid  (l2_valid),
        .l2_cmd    (l2_cmd),
        .l2_add    (l2_add),
        .l2_ready  (l2_ready),
        .full      (full),
        .occupancy (occupancy),
        .rd_issued (rd_issued),
        .wr_issued (wr_issued),
        .drop_cnt  (drop_cnt),
        .merge_cnt (merge_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag, input int rd, input int wr,
                                  input int dr, input int mg);
        check({tag, ".rd_issued"}, rd_issued, rd);
        check({tag, ".wr_issued"}, wr_issued, wr);
        check({tag, ".drop_cnt"},  drop_cnt,  dr);
        check({tag, ".merge_cnt"}, merge_cnt, mg);
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".occupancy"}, 32'(occupancy), 0);
        check({tag, ".l2_valid"},  32'(l2_valid),  0);
        check({tag, ".l2_cmd"},    32'(l2_cmd),    0);
        check({tag, ".l2_add"},    32'(l2_add),    0);
        check({tag, ".full"},      32'(full),      0);
    endtask

    initial begin
        rst_n    = 1'b0;
        cmd_in   = CMD_NOP;
        add_in   = '0;
        l2_ready = 1'b0;
        #12;
        check_empty("reset");
        check_counters("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Reserved and NOP codes are never stored or counted.
        for (int i = 0; i < 10; i++) begin
            cmd_in = (i % 2 == 0) ? CMD_RSVD : CMD_NOP;
            add_in = 26'h0ABC00 + 26'(i);
            tick();
        end
        cmd_in = CMD_NOP;
        check_empty("nop_rsvd");
        check_counters("nop_rsvd", 0, 0, 0, 0);

        // Single READ, L2 ready: visible after one edge, popped on the next.
        cmd_in   = CMD_READ;
        add_in   = 26'h0000123;
        l2_ready = 1'b1;
        tick();
        cmd_in = CMD_NOP;
        check("rd1.l2_valid", 32'(l2_valid), 1);
        check("rd1.l2_cmd",   32'(l2_cmd),   1);
        check("rd1.l2_add",   32'(l2_add),   32'h123);
        check("rd1.occupancy", 32'(occupancy), 1);
        tick();
        check_empty("rd1_after");
        check_counters("rd1_after", 1, 0, 0, 0);

        // Nine WRITEs with L2 stalled: eighth fills, ninth is dropped.
        l2_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cmd_in = CMD_WRITE;
            add_in = 26'h100 + 26'(i);
            tick();
            if (i == 6) check("ovf.full_at7", 32'(full), 0);
            if (i == 7) begin
                check("ovf.full_at8", 32'(full), 1);
                check("ovf.occ_at8",  32'(occupancy), 8);
            end
        end
        cmd_in = CMD_NOP;
        check("ovf.drop_cnt",  drop_cnt, 1);
        check("ovf.occupancy", 32'(occupancy), 8);
        check("ovf.head_stable", 32'(l2_add), 32'h100);
        tick();
        check("ovf.head_stable2", 32'(l2_add), 32'h100);
        l2_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain.add%0d", i), 32'(l2_add), 32'h100 + i);
            check($sformatf("drain.cmd%0d", i), 32'(l2_cmd), 2);
            tick();
        end
        check_empty("drain_done");
        check_counters("drain_done", 1, 8, 1, 0);

        // Refill, then push a READ while full and popping: accepted, no drop.
        l2_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cmd_in = CMD_WRITE;
            add_in = 26'h200 + 26'(i);
            tick();
        end
        check("fullpp.full_before", 32'(full), 1);
        cmd_in   = CMD_READ;
        add_in   = 26'h3AB;
        l2_ready = 1'b1;
        tick();
        cmd_in = CMD_NOP;
        check("fullpp.drop_cnt",  drop_cnt, 1);
        check("fullpp.occupancy", 32'(occupancy), 8);
        check("fullpp.head",      32'(l2_add), 32'h201);
        for (int i = 0; i < 7; i++) tick();
        check("fullpp.read_cmd", 32'(l2_cmd), 1);
        check("fullpp.read_add", 32'(l2_add), 32'h3AB);
        check("fullpp.read_occ", 32'(occupancy), 1);
        tick();
        check_empty("fullpp_done");
        check_counters("fullpp_done", 2, 16, 1, 0);

        // Asynchronous reset in the middle of a stalled drain.
        l2_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_in = CMD_WRITE;
            add_in = 26'h400 + 26'(i);
            tick();
        end
        cmd_in = CMD_NOP;
        check("rstmid.occ_before", 32'(occupancy), 5);
        #2 rst_n = 1'b0;
        #1;
        check_empty("rstmid");
        check_counters("rstmid", 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        tick();
        check_empty("rstmid_release");

        // WRITE A, WRITE A, READ A, WRITE A with L2 stalled.
        for (int i = 0; i < 4; i++) begin
            cmd_in = (i == 2) ? CMD_READ : CMD_WRITE;
            add_in = 26'h0A5A5A;
            tick();
        end
        cmd_in = CMD_NOP;
`ifdef WRITE_MERGE_EN
        check("merge.occupancy", 32'(occupancy), 3);
        check("merge.merge_cnt", merge_cnt, 1);
`else
        check("merge.occupancy", 32'(occupancy), 4);
        check("merge.merge_cnt", merge_cnt, 0);
`endif
        check("merge.drop_cnt", drop_cnt, 0);
        check("merge.head_cmd", 32'(l2_cmd), 2);
        check("merge.head_add", 32'(l2_add), 32'h0A5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
